// File: rtl/mul_div_unit_pkg.sv
// Shared datapath defines: multiply/divide op encodings and ALU control codes.
package mul_div_unit_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_ctrl_e;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit: shift-add multiply, restoring divide,
// one step per cycle on unsigned magnitudes with a final conditional negation.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             kill,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             Zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e             r_state;
  state_e             w_state_nx;
  logic [CW-1:0]      r_cnt;
  logic [2:0]         r_op;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_b;
  logic               r_neg_main;
  logic               r_neg_rem;
  logic [WIDTH-1:0]   r_result;

  // Operand decode at acceptance
  logic               w_is_div;
  logic               w_a_signed;
  logic               w_b_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_div0;
  logic               w_ovf;
  logic               w_special;
  logic [WIDTH-1:0]   w_special_res;
  logic               w_last;

  assign w_is_div   = op[2];
  assign w_a_signed = (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  assign w_b_signed = (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  assign w_a_neg    = w_a_signed & A[WIDTH-1];
  assign w_b_neg    = w_b_signed & B[WIDTH-1];
  assign w_a_mag    = w_a_neg ? -A : A;
  assign w_b_mag    = w_b_neg ? -B : B;
  assign w_div0     = w_is_div && (B == '0);
  assign w_ovf      = ((op == MD_DIV) || (op == MD_REM)) &&
                      (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1);
  assign w_special  = w_div0 | w_ovf;
  // op[1] separates the remainder ops from the quotient ops
  assign w_special_res = w_div0 ? (op[1] ? A : '1) : (op[1] ? '0 : A);
  assign w_last     = (r_cnt == CW'(WIDTH - 1));

  // Single shared adder: accumulate for multiply, trial subtract for divide
  logic [WIDTH-1:0]   w_add_a;
  logic [WIDTH-1:0]   w_add_b;
  logic               w_add_cin;
  logic [WIDTH:0]     w_add;
  logic               w_ge;
  logic [WIDTH-1:0]   w_acc_nx;
  logic [WIDTH-1:0]   w_q_nx;

  always_comb begin
    w_add_a   = r_acc;
    w_add_b   = r_q[0] ? r_b : '0;
    w_add_cin = 1'b0;
    if (r_op[2]) begin
      w_add_a   = {r_acc[WIDTH-2:0], r_q[WIDTH-1]};
      w_add_b   = ~r_b;
      w_add_cin = 1'b1;
    end
  end

  assign w_add = {1'b0, w_add_a} + {1'b0, w_add_b} + {{WIDTH{1'b0}}, w_add_cin};
  // The shifted-out partial remainder bit makes the trial value >= divisor too
  assign w_ge  = r_acc[WIDTH-1] | w_add[WIDTH];

  always_comb begin
    w_acc_nx = w_add[WIDTH:1];
    w_q_nx   = {w_add[0], r_q[WIDTH-1:1]};
    if (r_op[2]) begin
      w_acc_nx = w_ge ? w_add[WIDTH-1:0] : w_add_a;
      w_q_nx   = {r_q[WIDTH-2:0], w_ge};
    end
  end

  // Final sign fix-up applied on the step that enters DONE
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_f;
  logic [WIDTH-1:0]   w_final;

  assign w_prod   = {w_acc_nx, w_q_nx};
  assign w_prod_f = r_neg_main ? -w_prod : w_prod;

  always_comb begin
    w_final = '0;
    if (r_op[2]) begin
      if (r_op[1]) w_final = r_neg_rem  ? -w_acc_nx : w_acc_nx;
      else         w_final = r_neg_main ? -w_q_nx   : w_q_nx;
    end else if (r_op == MD_MUL) begin
      w_final = w_prod_f[WIDTH-1:0];
    end else begin
      w_final = w_prod_f[2*WIDTH-1:WIDTH];
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_nx = w_special ? S_DONE : S_CALC;
      S_CALC: begin
        if (kill)        w_state_nx = S_IDLE;
        else if (w_last) w_state_nx = S_DONE;
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_op       <= '0;
      r_acc      <= '0;
      r_q        <= '0;
      r_b        <= '0;
      r_neg_main <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_result   <= '0;
    end else begin
      r_state <= w_state_nx;
      if (r_state == S_IDLE && start) begin
        r_op       <= op;
        r_cnt      <= '0;
        r_acc      <= '0;
        r_q        <= w_is_div ? w_a_mag : w_b_mag;
        r_b        <= w_is_div ? w_b_mag : w_a_mag;
        r_neg_main <= w_a_neg ^ w_b_neg;
        r_neg_rem  <= w_a_neg;
        if (w_special) r_result <= w_special_res;
      end else if (r_state == S_CALC && !kill) begin
        r_acc <= w_acc_nx;
        r_q   <= w_q_nx;
        r_cnt <= r_cnt + CW'(1);
        if (w_last) r_result <= w_final;
      end
    end
  end

  assign busy   = (r_state == S_CALC);
  assign done   = (r_state == S_DONE);
  assign Result = r_result;
  assign Zero   = (r_result == '0);

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit (WIDTH=32): latency, results, kill/reset aborts.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         kill = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         zero;

  int total = 0;
  int bad = 0;
  int done_seen = 0;
  int ds = 0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .kill  (kill),
    .op    (op),
    .A     (a),
    .B     (b),
    .busy  (busy),
    .done  (done),
    .Result(result),
    .Zero  (zero)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_seen++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive start (and release kill) for exactly one accepting edge
  task automatic launch(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    kill = 1'b0;
  endtask

  // cyc0: cycles already elapsed since the accepting edge (all assumed busy)
  task automatic wait_done(input string tag, input logic [W-1:0] exp_res,
                           input int exp_lat, input int cyc0);
    int cyc;
    int bc;
    bit got;
    cyc = cyc0;
    bc  = cyc0;
    got = 1'b0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (done) got = 1'b1;
      else if (busy) bc++;
    end
    chk({tag, "_lat"}, W'(cyc), W'(exp_lat));
    chk({tag, "_res"}, result, exp_res);
    chk({tag, "_busy_cycles"}, W'(bc), W'(exp_lat - 1));
    chk({tag, "_zero"}, W'(zero), W'(exp_res == '0));
    @(negedge clk);
    chk({tag, "_done_pulse"}, W'(done), W'(0));
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] exp_res, input int exp_lat);
    @(negedge clk);
    launch(o, x, y);
    wait_done(tag, exp_res, exp_lat, 0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_result", result, '0);
    chk("rst_zero", W'(zero), W'(1));

    // First edge after reset release accepts start
    rst = 1'b0;
    launch(MD_DIVU, 32'd5, 32'd0);
    wait_done("divu_by0_first", 32'hFFFF_FFFF, 1, 0);

    run_op("mul",     MD_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run_op("mulh",    MD_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    run_op("mulhu",   MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("mulhsu",  MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    run_op("div",     MD_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
    run_op("rem",     MD_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
    run_op("divu",    MD_DIVU,   32'd100,       32'd7,         32'd14,        33);
    run_op("remu",    MD_REMU,   32'd100,       32'd7,         32'd2,         33);
    run_op("remu_by0", MD_REMU,  32'd5,         32'd0,         32'd5,         1);
    run_op("div_ovf", MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf", MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
    run_op("div_by0", MD_DIV,    32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFFF, 1);
    run_op("rem_by0", MD_REM,    32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 1);
    run_op("div_negb", MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    run_op("rem_negb", MD_REM,   32'd7,         32'hFFFF_FFFE, 32'd1,         33);
    run_op("mulh_neg", MD_MULH,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 33);
    run_op("mul_sh",  MD_MUL,    32'h1234_5678, 32'h10,        32'h2345_6780, 33);
    run_op("mulhu_sh", MD_MULHU, 32'h1234_5678, 32'h10,        32'd1,         33);
    run_op("div_min1", MD_DIV,   32'h8000_0000, 32'd1,         32'h8000_0000, 33);
    run_op("divu_big", MD_DIVU,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33);

    // Start during CALC is ignored
    @(negedge clk);
    launch(MD_DIVU, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    chk("ign_busy_c5", W'(busy), W'(1));
    op = MD_MUL;
    a = 32'd3;
    b = 32'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("ign_start", 32'd14, 33, 5);

    // Kill at cycle 10: idle at cycle 11, no done, Result held
    @(negedge clk);
    launch(MD_MUL, 32'd7, 32'd3);
    ds = done_seen;
    repeat (10) @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    @(negedge clk);
    chk("kill_busy", W'(busy), W'(0));
    chk("kill_done", W'(done), W'(0));
    chk("kill_result_held", result, 32'd14);
    repeat (40) @(negedge clk);
    chk("kill_no_done", W'(done_seen - ds), W'(0));

    // Kill together with start in IDLE: the start wins
    @(negedge clk);
    kill = 1'b1;
    launch(MD_MUL, 32'd6, 32'd7);
    wait_done("kill_with_start", 32'd42, 33, 0);

    // Reset at cycle 20 aborts without done
    @(negedge clk);
    launch(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    ds = done_seen;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", W'(busy), W'(0));
    chk("midrst_done", W'(done), W'(0));
    chk("midrst_result", result, '0);
    chk("midrst_zero", W'(zero), W'(1));
    repeat (40) @(negedge clk);
    chk("midrst_no_done", W'(done_seen - ds), W'(0));

    run_op("mul_wrap", MD_MUL, 32'h0001_0000, 32'h0001_0000, 32'd0, 33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
